// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
//
// Mode/edit sequencer for the digital clock datapath. Owns the RUN/SET state
// machine, gates the 1 Hz tick into the hh:mm:ss counter, loads edited
// hours/minutes into that counter, stores the alarm time and rings the alarm
// on an hh:mm:00 match.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   Defined   : btn_inc while ringing in RUN snoozes the alarm for SNOOZE_MIN
//               minutes of tick_1hz_in pulses, after which it rings again.
//   Undefined : btn_inc in RUN is ignored and no snooze counter exists.
//
// Parameters
//   ALARM_SECONDS  ticks alarm_on stays high before auto-clear (1..255)
//   SNOOZE_MIN     snooze delay in minutes, snooze build only (1..59)
//
// Ports
//   clk            system clock, all logic on posedge
//   reset_n        asynchronous active-low reset
//   tick_1hz_in    one-clk pulse per second
//   btn_mode       debounced level, rising edge advances the FSM
//   btn_inc        debounced level, rising edge increments the field under edit
//   btn_alarm_off  debounced level, rising edge dismisses the alarm
//   cur_hours      live counter hours   (0..23)
//   cur_minutes    live counter minutes (0..59)
//   cur_seconds    live counter seconds (0..59)
//   tick_out       gated tick to the counter
//   load           one-clk pulse: counter takes load_hours/load_minutes, sec:=0
//   load_hours     edited hours
//   load_minutes   edited minutes
//   alarm_hours    stored alarm hours
//   alarm_minutes  stored alarm minutes
//   alarm_on       alarm ringing
//   mode_state     FSM state encoding for the display mux
//   edit_blink     blink phase for the field under edit
// -----------------------------------------------------------------------------
module clock_set_controller #(
   parameter int ALARM_SECONDS = 60,
   parameter int SNOOZE_MIN    = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick_1hz_in,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_alarm_off,
   input  logic [4:0] cur_hours,
   input  logic [5:0] cur_minutes,
   input  logic [5:0] cur_seconds,
   output logic       tick_out,
   output logic       load,
   output logic [4:0] load_hours,
   output logic [5:0] load_minutes,
   output logic [4:0] alarm_hours,
   output logic [5:0] alarm_minutes,
   output logic       alarm_on,
   output logic [2:0] mode_state,
   output logic       edit_blink
);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HR   = 3'd1,
      SET_MIN  = 3'd2,
      SET_AHR  = 3'd3,
      SET_AMIN = 3'd4
   } state_e;

   // Elaboration-time guard on the parameter ranges.
   if (ALARM_SECONDS < 1 || ALARM_SECONDS > 255) begin : g_bad_alarm_seconds
      $error("ALARM_SECONDS must be in 1..255");
   end
   if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze_min
      $error("SNOOZE_MIN must be in 1..59");
   end

   localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECONDS - 1);

   state_e     state_q, state_d;
   logic       btn_mode_q, btn_inc_q, btn_off_q;
   logic [4:0] load_hours_q, load_hours_d;
   logic [5:0] load_minutes_q, load_minutes_d;
   logic [4:0] alarm_hours_q, alarm_hours_d;
   logic [5:0] alarm_minutes_q, alarm_minutes_d;
   logic       load_q, load_d;
   logic       armed_q, armed_d;
   logic       blink_q, blink_d;
   logic       match_q;
   logic       alarm_on_q, alarm_on_d;
   logic [7:0] alarm_cnt_q, alarm_cnt_d;

`ifdef ALARM_SNOOZE_EN
   localparam logic [11:0] SNOOZE_TICKS = 12'(SNOOZE_MIN * 60);
   logic [11:0] snooze_cnt_q, snooze_cnt_d;
`endif

   logic mode_press, inc_press, off_press, match;

   function automatic logic [4:0] next_hours(input logic [4:0] h);
      return (h == 5'd23) ? 5'd0 : h + 5'd1;
   endfunction

   function automatic logic [5:0] next_minutes(input logic [5:0] m);
      return (m == 6'd59) ? 6'd0 : m + 6'd1;
   endfunction

   // Rising-edge detection; a simultaneous mode press swallows the inc press.
   assign mode_press = btn_mode & ~btn_mode_q;
   assign inc_press  = btn_inc & ~btn_inc_q & ~mode_press;
   assign off_press  = btn_alarm_off & ~btn_off_q;

   assign match = armed_q && (state_q == RUN) &&
                  (cur_hours == alarm_hours_q) && (cur_minutes == alarm_minutes_q) &&
                  (cur_seconds == 6'd0);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d         = state_q;
      load_hours_d    = load_hours_q;
      load_minutes_d  = load_minutes_q;
      alarm_hours_d   = alarm_hours_q;
      alarm_minutes_d = alarm_minutes_q;
      load_d          = 1'b0;
      armed_d         = armed_q;
      blink_d         = blink_q;
      alarm_on_d      = alarm_on_q;
      alarm_cnt_d     = alarm_cnt_q;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_d    = snooze_cnt_q;
`endif

      // Mode/edit sequencing.
      if (mode_press) begin
         case (state_q)
            RUN: begin
               state_d        = SET_HR;
               load_hours_d   = cur_hours;
               load_minutes_d = cur_minutes;
            end
            SET_HR:  state_d = SET_MIN;
            SET_MIN: begin
               state_d = SET_AHR;
               load_d  = 1'b1;
            end
            SET_AHR: state_d = SET_AMIN;
            SET_AMIN: begin
               state_d = RUN;
               armed_d = 1'b1;
            end
            default: state_d = RUN;
         endcase
      end else if (inc_press) begin
         case (state_q)
            SET_HR:   load_hours_d    = next_hours(load_hours_q);
            SET_MIN:  load_minutes_d  = next_minutes(load_minutes_q);
            SET_AHR:  alarm_hours_d   = next_hours(alarm_hours_q);
            SET_AMIN: alarm_minutes_d = next_minutes(alarm_minutes_q);
            default: ;
         endcase
      end

      // Blink phase restarts at 0 on every state change and idles at 0 in RUN.
      if (mode_press || state_q == RUN) begin
         blink_d = 1'b0;
      end else if (tick_1hz_in) begin
         blink_d = ~blink_q;
      end

      // Ring timeout: the tick that reaches ALARM_SECONDS clears the alarm.
      if (alarm_on_q && tick_1hz_in) begin
         if (alarm_cnt_q == ALARM_LAST) begin
            alarm_on_d = 1'b0;
         end else begin
            alarm_cnt_d = alarm_cnt_q + 8'd1;
         end
      end

      if (alarm_on_q && off_press) begin
         alarm_on_d = 1'b0;
      end

`ifdef ALARM_SNOOZE_EN
      if (snooze_cnt_q != 12'd0 && tick_1hz_in) begin
         snooze_cnt_d = snooze_cnt_q - 12'd1;
         if (snooze_cnt_q == 12'd1) begin
            alarm_on_d  = 1'b1;
            alarm_cnt_d = 8'd0;
         end
      end
      if (state_q == RUN && alarm_on_q && inc_press) begin
         alarm_on_d   = 1'b0;
         snooze_cnt_d = SNOOZE_TICKS;
      end
      if (off_press || mode_press) begin
         snooze_cnt_d = 12'd0;
      end
`endif

      // A fresh match second starts a new ring window and supersedes any snooze.
      if (match && !match_q) begin
         alarm_on_d  = 1'b1;
         alarm_cnt_d = 8'd0;
`ifdef ALARM_SNOOZE_EN
         snooze_cnt_d = 12'd0;
`endif
      end

      // Leaving RUN always silences the alarm.
      if (mode_press) begin
         alarm_on_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= RUN;
         btn_mode_q      <= 1'b0;
         btn_inc_q       <= 1'b0;
         btn_off_q       <= 1'b0;
         load_hours_q    <= 5'd0;
         load_minutes_q  <= 6'd0;
         alarm_hours_q   <= 5'd0;
         alarm_minutes_q <= 6'd0;
         load_q          <= 1'b0;
         armed_q         <= 1'b0;
         blink_q         <= 1'b0;
         match_q         <= 1'b0;
         alarm_on_q      <= 1'b0;
         alarm_cnt_q     <= 8'd0;
`ifdef ALARM_SNOOZE_EN
         snooze_cnt_q    <= 12'd0;
`endif
      end else begin
         state_q         <= state_d;
         btn_mode_q      <= btn_mode;
         btn_inc_q       <= btn_inc;
         btn_off_q       <= btn_alarm_off;
         load_hours_q    <= load_hours_d;
         load_minutes_q  <= load_minutes_d;
         alarm_hours_q   <= alarm_hours_d;
         alarm_minutes_q <= alarm_minutes_d;
         load_q          <= load_d;
         armed_q         <= armed_d;
         blink_q         <= blink_d;
         match_q         <= match;
         alarm_on_q      <= alarm_on_d;
         alarm_cnt_q     <= alarm_cnt_d;
`ifdef ALARM_SNOOZE_EN
         snooze_cnt_q    <= snooze_cnt_d;
`endif
      end
   end

   // The tick passes straight through so the counter sees it in the same
   // cycle; reset_n is folded in so the output is also 0 while held in reset.
   assign tick_out = tick_1hz_in & reset_n &
                     ((state_q == RUN) || (state_q == SET_AHR) || (state_q == SET_AMIN));

   assign load          = load_q;
   assign load_hours    = load_hours_q;
   assign load_minutes  = load_minutes_q;
   assign alarm_hours   = alarm_hours_q;
   assign alarm_minutes = alarm_minutes_q;
   assign alarm_on      = alarm_on_q;
   assign mode_state    = state_q;
   assign edit_blink    = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_set_controller
//
// Self-checking bench for clock_set_controller. A behavioural model of the
// clock-setting rules (mode index, modulo arithmetic on times, ring/snooze
// second counts) predicts the expected load pulses and alarm transitions and
// pushes them into queues; a negedge monitor pops and compares whenever the DUT
// presents a load pulse or an alarm_on change. Registers and counts are also
// compared against the model after each stimulus step.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_set_controller;

   localparam int ALARM_SECONDS = 60;
   localparam int SNOOZE_MIN    = 5;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tick_1hz_in, btn_mode, btn_inc, btn_alarm_off;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes, cur_seconds;
   logic       tick_out, load, alarm_on, edit_blink;
   logic [4:0] load_hours, alarm_hours;
   logic [5:0] load_minutes, alarm_minutes;
   logic [2:0] mode_state;

   always #5 clk = ~clk;

   clock_set_controller #(
      .ALARM_SECONDS(ALARM_SECONDS),
      .SNOOZE_MIN   (SNOOZE_MIN)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick_1hz_in  (tick_1hz_in),
      .btn_mode     (btn_mode),
      .btn_inc      (btn_inc),
      .btn_alarm_off(btn_alarm_off),
      .cur_hours    (cur_hours),
      .cur_minutes  (cur_minutes),
      .cur_seconds  (cur_seconds),
      .tick_out     (tick_out),
      .load         (load),
      .load_hours   (load_hours),
      .load_minutes (load_minutes),
      .alarm_hours  (alarm_hours),
      .alarm_minutes(alarm_minutes),
      .alarm_on     (alarm_on),
      .mode_state   (mode_state),
      .edit_blink   (edit_blink)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int h;
      int m;
   } hm_t;

   hm_t exp_load[$];
   int  exp_alarm[$];

   int  m_mode, m_lh, m_lm, m_ah, m_am;
   int  m_blink, m_ticks, m_snooze, m_ring_secs;
   bit  m_armed, m_alarm, m_prev_match;

   // ---------------- monitor ----------------
   bit   mon_en = 1'b0;
   logic prev_alarm;
   int   tick_seen = 0;
   hm_t  mon_e;

   always @(negedge clk) begin
      if (mon_en) begin
         if (tick_out === 1'b1) tick_seen++;
         if (load === 1'b1) begin
            check("load_pulse_expected", int'(exp_load.size() > 0), 1);
            if (exp_load.size() > 0) begin
               mon_e = exp_load.pop_front();
               check("load_hours", load_hours, mon_e.h);
               check("load_minutes", load_minutes, mon_e.m);
            end
         end
         if (alarm_on !== prev_alarm) begin
            check("alarm_edge_expected", int'(exp_alarm.size() > 0), 1);
            if (exp_alarm.size() > 0) check("alarm_edge", alarm_on, exp_alarm.pop_front());
            prev_alarm = alarm_on;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sync();
      check("mode_state", mode_state, m_mode);
      check("load_hours_reg", load_hours, m_lh);
      check("load_minutes_reg", load_minutes, m_lm);
      check("alarm_hours", alarm_hours, m_ah);
      check("alarm_minutes", alarm_minutes, m_am);
      check("alarm_on", alarm_on, int'(m_alarm));
      check("edit_blink", edit_blink, m_blink);
      check("tick_out_count", tick_seen, m_ticks);
   endtask

   task automatic eval_match();
      bit mt;
      mt = m_armed && (m_mode == 0) && (int'(cur_hours) == m_ah) &&
           (int'(cur_minutes) == m_am) && (cur_seconds == 6'd0);
      if (mt && !m_prev_match) begin
         if (!m_alarm) exp_alarm.push_back(1);
         m_alarm     = 1'b1;
         m_ring_secs = 0;
         m_snooze    = 0;
      end
      m_prev_match = mt;
   endtask

   task automatic set_cur(input int h, input int m, input int s);
      cur_hours   = 5'(h);
      cur_minutes = 6'(m);
      cur_seconds = 6'(s);
      eval_match();
      step();
      sync();
   endtask

   task automatic do_tick();
      if (m_mode == 0 || m_mode >= 3) m_ticks++;
      if (m_mode != 0) m_blink ^= 1;
      if (m_alarm) begin
         m_ring_secs++;
         if (m_ring_secs == ALARM_SECONDS) begin
            m_alarm = 1'b0;
            exp_alarm.push_back(0);
         end
      end else if (m_snooze > 0) begin
         m_snooze--;
         if (m_snooze == 0) begin
            m_alarm     = 1'b1;
            m_ring_secs = 0;
            exp_alarm.push_back(1);
         end
      end
      tick_1hz_in = 1'b1;
      step();
      tick_1hz_in = 1'b0;
      step();
      sync();
   endtask

   task automatic press_mode(input bit with_inc);
      if (m_alarm) begin
         m_alarm = 1'b0;
         exp_alarm.push_back(0);
      end
      m_snooze = 0;
      case (m_mode)
         0: begin
            m_lh = int'(cur_hours);
            m_lm = int'(cur_minutes);
         end
         2: exp_load.push_back('{h: m_lh, m: m_lm});
         4: m_armed = 1'b1;
         default: ;
      endcase
      m_mode  = (m_mode + 1) % 5;
      m_blink = 0;
      eval_match();
      btn_mode = 1'b1;
      btn_inc  = with_inc;
      step();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step();
      sync();
   endtask

   task automatic press_inc();
      case (m_mode)
         1: m_lh = (m_lh + 1) % 24;
         2: m_lm = (m_lm + 1) % 60;
         3: m_ah = (m_ah + 1) % 24;
         4: m_am = (m_am + 1) % 60;
         default: begin
`ifdef ALARM_SNOOZE_EN
            if (m_alarm) begin
               m_alarm  = 1'b0;
               m_snooze = SNOOZE_MIN * 60;
               exp_alarm.push_back(0);
            end
`endif
         end
      endcase
      btn_inc = 1'b1;
      step();
      btn_inc = 1'b0;
      step();
      sync();
   endtask

   task automatic press_off();
      if (m_alarm) begin
         m_alarm = 1'b0;
         exp_alarm.push_back(0);
      end
      m_snooze = 0;
      btn_alarm_off = 1'b1;
      step();
      btn_alarm_off = 1'b0;
      step();
      sync();
   endtask

   task automatic apply_reset();
      if (m_alarm) exp_alarm.push_back(0);
      reset_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick_1hz_in   = 1'($urandom);
         btn_mode      = 1'($urandom);
         btn_inc       = 1'($urandom);
         btn_alarm_off = 1'($urandom);
         cur_hours     = 5'($urandom_range(0, 23));
         cur_minutes   = 6'($urandom_range(0, 59));
         cur_seconds   = 6'($urandom_range(0, 59));
         step();
         check("rst_tick_out", tick_out, 0);
         check("rst_load", load, 0);
         check("rst_load_hours", load_hours, 0);
         check("rst_load_minutes", load_minutes, 0);
         check("rst_alarm_hours", alarm_hours, 0);
         check("rst_alarm_minutes", alarm_minutes, 0);
         check("rst_alarm_on", alarm_on, 0);
         check("rst_mode_state", mode_state, 0);
         check("rst_edit_blink", edit_blink, 0);
      end
      tick_1hz_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm_off = 1'b0;
      m_mode = 0; m_lh = 0; m_lm = 0; m_ah = 0; m_am = 0;
      m_blink = 0; m_snooze = 0; m_ring_secs = 0;
      m_armed = 1'b0; m_alarm = 1'b0; m_prev_match = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      sync();
   endtask

   // ---------------- test sequence ----------------
   int t0, n_inc;

   initial begin
      reset_n = 1'b0;
      tick_1hz_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm_off = 1'b0;
      cur_hours = '0; cur_minutes = '0; cur_seconds = '0;
      m_ticks = 0;
      repeat (2) step();
      prev_alarm = alarm_on;
      mon_en     = 1'b1;

      // T1: reset with toggling inputs.
      apply_reset();

      // T2: set time from 10:15, hours wrap 23->0, minutes to 17, load 00:17.
      set_cur(10, 15, 30);
      press_mode(1'b0);
      repeat (14) press_inc();
      check("t2_hours_wrap", load_hours, 0);
      press_mode(1'b0);
      repeat (2) press_inc();
      check("t2_minutes", load_minutes, 17);
      press_mode(1'b0);
      check("t2_load_consumed", exp_load.size(), 0);

      // T3: ticks pass in SET_AHR, are dropped in SET_HR.
      t0 = tick_seen;
      repeat (5) do_tick();
      check("t3_ahr_ticks", tick_seen - t0, 5);
      press_mode(1'b0);
      press_mode(1'b0);
      press_mode(1'b0);
      t0 = tick_seen;
      repeat (5) do_tick();
      check("t3_set_hr_ticks", tick_seen - t0, 0);

      // T5: mode and inc together in SET_HR.
      press_mode(1'b1);
      check("t5_state", mode_state, 2);
      check("t5_hours_kept", load_hours, 10);

      // Set alarm 07:30 and return to RUN.
      press_mode(1'b0);
      n_inc = (7 - m_ah + 24) % 24;
      repeat (n_inc) press_inc();
      press_mode(1'b0);
      n_inc = (30 - m_am + 60) % 60;
      repeat (n_inc) press_inc();
      press_mode(1'b0);
      check("t4_alarm_hours", alarm_hours, 7);
      check("t4_alarm_minutes", alarm_minutes, 30);

      // T4: ring, dismiss with no retrigger, then auto-clear after 60 ticks.
      set_cur(7, 29, 59);
      set_cur(7, 30, 0);
      check("t4_alarm_rings", alarm_on, 1);
      repeat (3) step();
      press_off();
      repeat (5) step();
      check("t4_no_retrigger", alarm_on, 0);
      press_off();
      set_cur(7, 30, 1);
      set_cur(7, 30, 0);
      repeat (ALARM_SECONDS - 1) do_tick();
      check("t4_still_ringing", alarm_on, 1);
      do_tick();
      check("t4_auto_clear", alarm_on, 0);

      // T6: snooze (or inc ignored without the feature).
      set_cur(7, 30, 1);
      set_cur(7, 30, 0);
      press_inc();
`ifdef ALARM_SNOOZE_EN
      check("t6_snoozed", alarm_on, 0);
      repeat (SNOOZE_MIN * 60 - 1) do_tick();
      check("t6_still_snoozed", alarm_on, 0);
      do_tick();
      check("t6_rerings", alarm_on, 1);
`else
      check("t6_inc_ignored", alarm_on, 1);
`endif
      press_off();

      // Randomised edit rounds through all five states.
      for (int r = 0; r < 6; r++) begin
         set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
         for (int s = 0; s < 5; s++) begin
            n_inc = $urandom_range(0, 26);
            for (int k = 0; k < n_inc; k++) begin
               if ($urandom_range(0, 3) == 0) do_tick();
               else press_inc();
            end
            press_mode($urandom_range(0, 4) == 0);
         end
      end

      // Reset mid-edit: edit abandoned, no load pulse.
      press_mode(1'b0);
      press_mode(1'b0);
      press_inc();
      apply_reset();
      repeat (4) step();
      sync();

      check("load_queue_empty", exp_load.size(), 0);
      check("alarm_queue_empty", exp_alarm.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
